// File: rtl/dm_slave_if.sv
// Request/response bundle between the memory-access stage (master) and the
// data-memory responder (slave).
interface dm_slave_if;
    logic        DM_read;
    logic        DM_write;
    logic [31:0] DM_address;
    logic [31:0] DM_in;
    logic [31:0] DM_out;
    logic        DM_ready;
    logic        DM_error;
    logic        busy;

    modport master (
        output DM_read, DM_write, DM_address, DM_in,
        input  DM_out, DM_ready, DM_error, busy
    );

    modport slave (
        input  DM_read, DM_write, DM_address, DM_in,
        output DM_out, DM_ready, DM_error, busy
    );
endinterface

// File: rtl/dm_slave.sv
// Word-addressed data memory with a fixed number of wait states, a one-cycle
// ready pulse per request and an error pulse for illegal requests.
module dm_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic       clock,
    input logic       reset,
    dm_slave_if.slave bus
);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q;
    logic [3:0]            wcnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           data_q;
    logic                  isWrite_q;
    logic                  err_q;
    logic [31:0]           out_q;
    logic                  ready_q;
    logic                  error_q;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic                  strobe;
    logic                  reqErr;
    logic [ADDR_WIDTH-1:0] reqIdx;
    logic                  enterResp_d;
    logic [ADDR_WIDTH-1:0] idx_d;
    logic [31:0]           data_d;
    logic                  isWrite_d;
    logic                  err_d;
    logic                  doWrite;
    logic                  doRead;

    assign strobe = bus.DM_read | bus.DM_write;
    assign reqErr = (bus.DM_read & bus.DM_write)
                  | (bus.DM_address[1:0] != 2'b00)
                  | ((bus.DM_address >> (ADDR_WIDTH + 2)) != 32'd0);
    assign reqIdx = bus.DM_address[ADDR_WIDTH+1:2];

    // With zero wait states the access happens on the accepting edge itself,
    // so the live request is used instead of the latched copy.
    always_comb begin
        enterResp_d = 1'b0;
        idx_d       = idx_q;
        data_d      = data_q;
        isWrite_d   = isWrite_q;
        err_d       = err_q;
        if (state_q == IDLE) begin
            enterResp_d = strobe && ZERO_WAIT;
            idx_d       = reqIdx;
            data_d      = bus.DM_in;
            isWrite_d   = bus.DM_write;
            err_d       = reqErr;
        end else if (state_q == WAIT) begin
            enterResp_d = (wcnt_q == 4'd0);
        end
    end

    assign doWrite = enterResp_d && !err_d && isWrite_d && !reset;
    assign doRead  = enterResp_d && !err_d && !isWrite_d;

    always_ff @(posedge clock) begin
        if (doWrite) begin
            mem[idx_d] <= data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            wcnt_q    <= 4'd0;
            idx_q     <= '0;
            data_q    <= 32'd0;
            isWrite_q <= 1'b0;
            err_q     <= 1'b0;
            out_q     <= 32'd0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            if (doRead) begin
                out_q <= mem[idx_d];
            end
            if (enterResp_d) begin
                ready_q <= 1'b1;
                error_q <= err_d;
            end
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        idx_q     <= reqIdx;
                        data_q    <= bus.DM_in;
                        isWrite_q <= bus.DM_write;
                        err_q     <= reqErr;
                        if (ZERO_WAIT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            wcnt_q  <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wcnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.DM_out   = out_q;
    assign bus.DM_ready = ready_q;
    assign bus.DM_error = error_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_dm_slave.sv
// Directed bench for dm_slave: a two-wait-state instance driven from a vector
// table plus hand sequences, and a zero-wait instance for the W=0 timing.
module tb_dm_slave;
    localparam int W = 2;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    dm_slave_if bus2 ();
    dm_slave_if bus0 ();

    dm_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    dm_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic        expErr;
        logic [31:0] expOut;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic readyOf(input bit useZero);
        return useZero ? bus0.DM_ready : bus2.DM_ready;
    endfunction

    function automatic logic errorOf(input bit useZero);
        return useZero ? bus0.DM_error : bus2.DM_error;
    endfunction

    function automatic logic [31:0] outOf(input bit useZero);
        return useZero ? bus0.DM_out : bus2.DM_out;
    endfunction

    function automatic logic busyOf(input bit useZero);
        return useZero ? bus0.busy : bus2.busy;
    endfunction

    task automatic dropStrobes();
        bus2.DM_read  = 1'b0;
        bus2.DM_write = 1'b0;
        bus0.DM_read  = 1'b0;
        bus0.DM_write = 1'b0;
    endtask

    // One full request: raise strobes, drop them after the accepting edge,
    // then measure ready latency and check the response and pulse width.
    task automatic applyStimulus(input bit useZero, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] din,
                                 input logic expErr, input logic [31:0] expOut,
                                 input string name);
        int lat;
        if (useZero) begin
            bus0.DM_read = rd; bus0.DM_write = wr; bus0.DM_address = addr; bus0.DM_in = din;
        end else begin
            bus2.DM_read = rd; bus2.DM_write = wr; bus2.DM_address = addr; bus2.DM_in = din;
        end
        @(posedge clock); #1;
        dropStrobes();
        lat = 0;
        while (!readyOf(useZero) && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), useZero ? 32'd0 : 32'(W));
        checkOutput({name, " error"}, 32'(errorOf(useZero)), 32'(expErr));
        checkOutput({name, " data"}, outOf(useZero), expOut);
        @(posedge clock); #1;
        checkOutput({name, " pulse end"}, 32'(readyOf(useZero)), 32'd0);
        checkOutput({name, " error end"}, 32'(errorOf(useZero)), 32'd0);
        checkOutput({name, " busy end"}, 32'(busyOf(useZero)), 32'd0);
        checkOutput({name, " data hold"}, outOf(useZero), expOut);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int readyCount;
        int firstAt;
        int secondAt;
        logic [31:0] outAtSecond;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus2.DM_address = 32'd0; bus2.DM_in = 32'd0;
        bus0.DM_address = 32'd0; bus0.DM_in = 32'd0;
        dropStrobes();

        vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        "wr 0x10"});
        vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, "rd 0x10"});
        vecs.push_back('{1'b0, 1'b1, 32'h0,        32'h11111111, 1'b0, 32'hDEADBEEF, "wr 0x0"});
        vecs.push_back('{1'b0, 1'b1, 32'h4,        32'h00000077, 1'b0, 32'hDEADBEEF, "wr 0x4"});
        vecs.push_back('{1'b0, 1'b1, 32'h20,       32'h12345678, 1'b0, 32'hDEADBEEF, "wr 0x20"});
        vecs.push_back('{1'b1, 1'b0, 32'h12,       32'h0,        1'b1, 32'hDEADBEEF, "rd misaligned"});
        vecs.push_back('{1'b0, 1'b1, 32'h1000,     32'h00000BAD, 1'b1, 32'hDEADBEEF, "wr out of range"});
        vecs.push_back('{1'b1, 1'b1, 32'h4,        32'h00000BAD, 1'b1, 32'hDEADBEEF, "both strobes"});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h0,        1'b1, 32'hDEADBEEF, "rd high bit"});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h11111111, "rd 0x0"});
        vecs.push_back('{1'b1, 1'b0, 32'h4,        32'h0,        1'b0, 32'h00000077, "rd 0x4"});
        vecs.push_back('{1'b0, 1'b1, 32'h8,        32'h00000099, 1'b0, 32'h00000077, "wr 0x8 hold"});
        vecs.push_back('{1'b0, 1'b1, 32'hFFC,      32'hCAFEF00D, 1'b0, 32'h00000077, "wr top word"});
        vecs.push_back('{1'b1, 1'b0, 32'hFFC,      32'h0,        1'b0, 32'hCAFEF00D, "rd top word"});
        vecs.push_back('{1'b1, 1'b0, 32'h8,        32'h0,        1'b0, 32'h00000099, "rd 0x8"});

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset ready", 32'(bus2.DM_ready), 32'd0);
        checkOutput("reset error", 32'(bus2.DM_error), 32'd0);
        checkOutput("reset out", bus2.DM_out, 32'd0);
        checkOutput("reset busy", 32'(bus2.busy), 32'd0);
        checkOutput("reset out w0", bus0.DM_out, 32'd0);
        checkOutput("reset busy w0", 32'(bus0.busy), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din,
                          vecs[i].expErr, vecs[i].expOut, vecs[i].name);
        end

        // Strobe held for W+3 edges: second acceptance on the edge after RESP.
        readyCount = 0; firstAt = -1; secondAt = -1; outAtSecond = 32'd0;
        bus2.DM_read = 1'b1; bus2.DM_address = 32'h8;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge clock); #1;
            if (cyc == W + 2) bus2.DM_read = 1'b0;
            if (bus2.DM_ready) begin
                readyCount++;
                if (firstAt < 0) firstAt = cyc;
                else if (secondAt < 0) begin
                    secondAt    = cyc;
                    outAtSecond = bus2.DM_out;
                end
            end
        end
        checkOutput("held strobe ready count", 32'(readyCount), 32'd2);
        checkOutput("held strobe first ready", 32'(firstAt), 32'(W));
        checkOutput("held strobe second ready", 32'(secondAt), 32'(2 * W + 2));
        checkOutput("held strobe data", outAtSecond, 32'h00000099);

        // Reset during WAIT discards the pending write.
        bus2.DM_write = 1'b1; bus2.DM_address = 32'h20; bus2.DM_in = 32'hA5A5A5A5;
        @(posedge clock); #1;
        dropStrobes();
        checkOutput("abort busy in wait", 32'(bus2.busy), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("abort ready", 32'(bus2.DM_ready), 32'd0);
        checkOutput("abort error", 32'(bus2.DM_error), 32'd0);
        checkOutput("abort out", bus2.DM_out, 32'd0);
        checkOutput("abort busy", 32'(bus2.busy), 32'd0);
        readyCount = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (bus2.DM_ready) readyCount++;
        end
        checkOutput("abort no ready", 32'(readyCount), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, "rd 0x20 after abort");

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 32'h0, "w0 wr 0x0");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1, "w0 rd 0x0");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h2, 32'h0, 1'b1, 32'h1, "w0 rd misaligned");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dm_slave.md
# dm_slave

Data-memory responder for the multi-cycle core. It services the controller's `DM_read`/`DM_write` strobes against an internal word-addressed array, with a parameterised wait-state count. It returns a one-cycle `DM_ready` completion pulse, plus `DM_error` for illegal requests. It sits between the controller/datapath memory-access stage and the on-chip data RAM, replacing the zero-latency behavioural memory so that the core can be exercised against realistic access latency.

## Interface
- `ADDR_WIDTH`, 10: word-index width; the array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states inserted before completion; legal range 0..15.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `DM_read` in 1: read request strobe.
- `DM_write` in 1: write request strobe.
- `DM_address` in 32: byte address.
- `DM_in` in 32: write data.
- `DM_out` out 32: read data, registered.
- `DM_ready` out 1: one-cycle completion pulse.
- `DM_error` out 1: one-cycle error pulse, only ever asserted together with `DM_ready`.
- `busy` out 1: high while a request is outstanding (state ≠ IDLE).

## Operation
- **States:** IDLE, WAIT, RESP. A 4-bit down-counter `wcnt` is used in WAIT.
- **Sampling:** strobes are sampled only in IDLE. Any strobe seen in WAIT or RESP is ignored.
- **Request acceptance:** at an IDLE edge with `DM_read | DM_write`, the block latches address, data, read/write type and the error flag.
- **Error flag:** set when any of the following hold:
  - both strobes are high;
  - `DM_address[1:0] != 0`;
  - any bit of `DM_address[31:ADDR_WIDTH+2]` is set.
- **Transitions:**
  - IDLE → WAIT with `wcnt = WAIT_CYCLES-1` when `WAIT_CYCLES > 0`.
  - IDLE → RESP when `WAIT_CYCLES == 0`.
  - WAIT: decrement `wcnt`; at `wcnt == 0` go to RESP.
  - RESP → IDLE unconditionally after one cycle.
- **Access:** performed on the edge that enters RESP, and only if the error flag is clear.
  - Write: `mem[addr[ADDR_WIDTH+1:2]] <= latched DM_in`.
  - Read: `DM_out <= mem[index]`.
- **Outputs in RESP:** `DM_ready = 1`; `DM_error = latched error flag`.
- **Error requests:** no array access; `DM_out` is unchanged.
- **`DM_out` hold:** `DM_out` holds its value until the next successful read completes. Writes do not change it.
- **Requestor rule:** the requestor drops its strobe no later than the `DM_ready` cycle. A strobe still high in the cycle after RESP (back in IDLE) is accepted as a new request.
- **Reset:**
  - Aborts any request; state goes to IDLE, `wcnt = 0`.
  - `DM_out = 0`, `DM_ready = 0`, `DM_error = 0`, `busy = 0`.
  - A write not yet committed is discarded.
  - Array contents are not cleared.

## Timing
- A request sampled at edge k gives `DM_ready` high from edge k+W to edge k+W+1, where W = `WAIT_CYCLES`.
  - W = 0: ready in the cycle immediately after acceptance.
  - W = 2: ready two cycles after that.
- `busy` is high from edge k to edge k+W+1.
- Read data is valid on `DM_out` in the `DM_ready` cycle and stays stable afterwards.
- Write data is visible to a read accepted at or after edge k+W+1 (read-after-write needs no bypass).
- Back-to-back throughput: one request per W+2 cycles.
- Reset asserted during WAIT or RESP takes effect at the next edge. Ready never pulses for the aborted request.

## Test plan
- **Write then read, W=2:** write 0xDEADBEEF to 0x10, then read 0x10.
  - Each `DM_ready` pulse is high exactly 1 cycle, 2 cycles after the sampling edge.
  - `DM_out = 0xDEADBEEF` in the read's ready cycle; `DM_error = 0`.
- **Zero-wait build (W=0):** write 0x1 to 0x0, then read 0x0.
  - Ready in the cycle after acceptance; `DM_out = 0x1`.
- **Illegal requests:** read at 0x12 (misaligned); write at 0x1000 with ADDR_WIDTH=10 (out of range); both strobes high at 0x4.
  - Each gives `DM_ready = DM_error = 1` for one cycle.
  - `mem[0]`, `mem[1]` and `DM_out` are unchanged (check by a later legal read).
- **Strobe during busy:** hold `DM_read` high for W+3 cycles at 0x8.
  - Exactly two requests are accepted: the second at the IDLE edge after RESP.
  - A second ready pulse appears W+2 cycles after the first.
- **Reset mid-operation:** write 0xA5A5A5A5 to 0x20; assert reset in the WAIT cycle.
  - Next cycle: all outputs 0 and IDLE.
  - A subsequent read of 0x20 returns the old value, not 0xA5A5A5A5.
- **Data hold:** read 0x4 (value 0x77), then write 0x99 to 0x8.
  - `DM_out` stays 0x77 through and after the write.
